mem_stage: RTL and testbench

- Memory-access pipeline stage between EX and WB.
- Accepts one instruction per handshake from EX, waits for the data-SRAM response of any load that EX issued, then aligns and extends the load data.
- Forwards the result and exception/CP0 fields to WB on the 87-bit MS-to-WS bus.
- Drops in-flight responses belonging to instructions flushed by a WB exception or ERET.

---
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and data bus bundle around the MEM pipeline stage: EX->MEM, MEM->WB,
// data-SRAM response, flush and hazard/status feedback.
interface mem_stage_if #(
  parameter int unsigned ES_TO_MS_BUS_WD = 91,
  parameter int unsigned MS_TO_WS_BUS_WD = 87
);
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       flush;
  logic [4:0]                 ms_rf_dest;
  logic [31:0]                ms_fwd_data;
  logic                       ms_fwd_ready;
  logic                       ms_inst_mfc0_o;
  logic                       ms_ex_o;

  // Environment side: EX, WB and the data SRAM
  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata, flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_rf_dest, ms_fwd_data, ms_fwd_ready,
           ms_inst_mfc0_o, ms_ex_o
  );

  // MEM stage side
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata, flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_rf_dest, ms_fwd_data, ms_fwd_ready,
           ms_inst_mfc0_o, ms_ex_o
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM load responses, aligns/extends load data,
// and drops responses that belong to instructions flushed while still waiting.
module mem_stage #(
  parameter int unsigned ES_TO_MS_BUS_WD = 91,
  parameter int unsigned MS_TO_WS_BUS_WD = 87
) (
  input logic           clk,
  input logic           resetn,
  mem_stage_if.slave    bus_io
);

  logic                       ms_valid_q;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;
  logic                       resp_buf_v_q;
  logic [31:0]                resp_buf_q;
  logic [1:0]                 cancel_cnt_q, cancel_cnt_d;

  logic [31:0] pc, alu_result;
  logic [4:0]  dest;
  logic [3:0]  gr_strb;
  logic        mtc0, mfc0, syscall, eret, bd, ex;
  logic [7:0]  cp0_addr;
  logic [2:0]  load_op;
  logic        need_resp;

  assign pc         = bus_q[31:0];
  assign alu_result = bus_q[63:32];
  assign dest       = bus_q[68:64];
  assign gr_strb    = bus_q[72:69];
  assign mtc0       = bus_q[73];
  assign mfc0       = bus_q[74];
  assign syscall    = bus_q[75];
  assign eret       = bus_q[76];
  assign bd         = bus_q[77];
  assign ex         = bus_q[78];
  assign cp0_addr   = bus_q[86:79];
  assign load_op    = bus_q[89:87];
  assign need_resp  = bus_q[90];

  logic resp_hit, ms_ready_go, ms_allowin, load_in, cancel_inc, cancel_dec;

  assign resp_hit    = bus_io.data_sram_data_ok && (cancel_cnt_q == 2'd0);
  assign ms_ready_go = !need_resp || resp_buf_v_q || (resp_hit && ms_valid_q);
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && bus_io.ws_allowin);
  assign load_in     = bus_io.es_to_ms_valid && ms_allowin;

  // A flushed entry whose response is still outstanding leaves one stale data_ok to discard
  assign cancel_inc = bus_io.flush && ms_valid_q && need_resp && !resp_buf_v_q && !resp_hit;
  assign cancel_dec = bus_io.data_sram_data_ok && (cancel_cnt_q != 2'd0);

  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    if (cancel_inc && !cancel_dec) begin
      if (cancel_cnt_q != 2'd3) cancel_cnt_d = cancel_cnt_q + 2'd1;
    end else if (cancel_dec && !cancel_inc) begin
      cancel_cnt_d = cancel_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      resp_buf_v_q <= 1'b0;
      resp_buf_q   <= '0;
      cancel_cnt_q <= 2'd0;
    end else begin
      cancel_cnt_q <= cancel_cnt_d;
      if (bus_io.flush) begin
        ms_valid_q <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_q <= bus_io.es_to_ms_valid;
      end
      if (load_in) begin
        bus_q        <= bus_io.es_to_ms_bus;
        resp_buf_v_q <= 1'b0;
      end else if (resp_hit && ms_valid_q && need_resp && !resp_buf_v_q) begin
        // Hold the response while WB stalls so it is never lost
        resp_buf_q   <= bus_io.data_sram_rdata;
        resp_buf_v_q <= 1'b1;
      end
    end
  end

  logic [31:0] load_data, load_ext, final_result;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_data = resp_buf_v_q ? resp_buf_q : bus_io.data_sram_rdata;
  assign load_half = alu_result[1] ? load_data[31:16] : load_data[15:0];

  always_comb begin
    load_byte = load_data[7:0];
    unique case (alu_result[1:0])
      2'd0: load_byte = load_data[7:0];
      2'd1: load_byte = load_data[15:8];
      2'd2: load_byte = load_data[23:16];
      2'd3: load_byte = load_data[31:24];
    endcase
  end

  always_comb begin
    load_ext     = load_data;
    final_result = alu_result;
    case (load_op)
      3'd1: load_ext = {{24{load_byte[7]}}, load_byte};
      3'd2: load_ext = {24'd0, load_byte};
      3'd3: load_ext = {{16{load_half[15]}}, load_half};
      3'd4: load_ext = {16'd0, load_half};
      default: load_ext = load_data;
    endcase
    if (load_op >= 3'd1 && load_op <= 3'd5) final_result = load_ext;
  end

  assign bus_io.ms_allowin     = ms_allowin;
  assign bus_io.ms_to_ws_valid = ms_valid_q && ms_ready_go && !bus_io.flush;
  assign bus_io.ms_to_ws_bus   = {cp0_addr, ex, bd, eret, syscall, mfc0, mtc0, gr_strb, dest,
                                  final_result, pc};
  assign bus_io.ms_rf_dest     = (ms_valid_q && gr_strb != 4'd0) ? dest : 5'd0;
  assign bus_io.ms_fwd_data    = final_result;
  assign bus_io.ms_fwd_ready   = ms_valid_q && ms_ready_go;
  assign bus_io.ms_inst_mfc0_o = ms_valid_q && mfc0;
  assign bus_io.ms_ex_o        = ms_valid_q && ex;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load alignment, late/stalled responses,
// flush cancellation and asynchronous reset during a pending load.
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  mem_stage_if #(.ES_TO_MS_BUS_WD(91), .MS_TO_WS_BUS_WD(87)) bif ();

  mem_stage #(.ES_TO_MS_BUS_WD(91), .MS_TO_WS_BUS_WD(87)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_io (bif.slave)
  );

  always #5 clk = ~clk;

  // flags = {ex, bd, eret, syscall, mfc0, mtc0}
  function automatic logic [90:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [4:0] dest, input logic [3:0] strb,
                                         input logic [5:0] flags, input logic [7:0] cp0,
                                         input logic [2:0] lop, input logic req);
    mk_bus = {req, lop, cp0, flags, strb, dest, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bif.es_to_ms_valid = 1'b0;
    bif.es_to_ms_bus = '0;
    bif.ws_allowin = 1'b1;
    bif.data_sram_data_ok = 1'b0;
    bif.data_sram_rdata = '0;
    bif.flush = 1'b0;
    #12;
    tests++; if (bif.ms_allowin !== 1'b1) begin
      fails++; $display("FAIL reset_allowin got %b want 1", bif.ms_allowin); end
    tests++; if (bif.ms_to_ws_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", bif.ms_to_ws_valid); end
    tests++; if (bif.ms_to_ws_bus !== 87'd0) begin
      fails++; $display("FAIL reset_bus got %h want 0", bif.ms_to_ws_bus); end
    tests++; if ({bif.ms_rf_dest, bif.ms_fwd_ready, bif.ms_inst_mfc0_o, bif.ms_ex_o} !== 8'd0)
    begin
      fails++; $display("FAIL reset_status got %h want 0",
                        {bif.ms_rf_dest, bif.ms_fwd_ready, bif.ms_inst_mfc0_o, bif.ms_ex_o});
    end
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    tick();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus = mk_bus(32'hBFC00010, 32'h1234, 5'd5, 4'hF, 6'b100010, 8'h60, 3'd0, 1'b0);
    tick();
    bif.es_to_ms_valid = 1'b0;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b1) begin
      fails++; $display("FAIL alu_valid got %b want 1", bif.ms_to_ws_valid); end
    tests++; if (bif.ms_to_ws_bus[63:32] !== 32'h1234) begin
      fails++; $display("FAIL alu_result got %h want 00001234", bif.ms_to_ws_bus[63:32]); end
    tests++; if (bif.ms_to_ws_bus[31:0] !== 32'hBFC00010) begin
      fails++; $display("FAIL alu_pc got %h want bfc00010", bif.ms_to_ws_bus[31:0]); end
    tests++; if (bif.ms_to_ws_bus[86:64] !== {8'h60, 6'b100010, 4'hF, 5'd5}) begin
      fails++; $display("FAIL alu_fields got %h want %h", bif.ms_to_ws_bus[86:64],
                        {8'h60, 6'b100010, 4'hF, 5'd5}); end
    tests++; if ({bif.ms_fwd_ready, bif.ms_rf_dest, bif.ms_inst_mfc0_o, bif.ms_ex_o} !==
                 {1'b1, 5'd5, 1'b1, 1'b1}) begin
      fails++; $display("FAIL alu_status got %b want 10010111",
                        {bif.ms_fwd_ready, bif.ms_rf_dest, bif.ms_inst_mfc0_o, bif.ms_ex_o});
    end
    tick();
    tests++; if (bif.ms_to_ws_valid !== 1'b0 || bif.ms_rf_dest !== 5'd0) begin
      fails++; $display("FAIL alu_drain got valid=%b dest=%0d want 0 0",
                        bif.ms_to_ws_valid, bif.ms_rf_dest); end
  endtask

  task automatic test_load_align();
    logic [2:0]  ops  [2] = '{3'd1, 3'd4};
    logic [31:0] addr [2] = '{32'h1003, 32'h2002};
    logic [31:0] exp  [2] = '{32'hFFFFFF80, 32'h000080FF};
    for (int i = 0; i < 2; i++) begin
      bif.es_to_ms_valid = 1'b1;
      bif.es_to_ms_bus = mk_bus(32'h100 + i, addr[i], 5'd3, 4'hF, 6'd0, 8'd0, ops[i], 1'b1);
      tick();
      bif.es_to_ms_valid = 1'b0;
      bif.data_sram_data_ok = 1'b1;
      bif.data_sram_rdata = 32'h80FF1234;
      #1;
      tests++; if (bif.ms_to_ws_valid !== 1'b1 || bif.ms_to_ws_bus[63:32] !== exp[i]) begin
        fails++; $display("FAIL align_%0d got valid=%b data=%h want 1 %h", i,
                          bif.ms_to_ws_valid, bif.ms_to_ws_bus[63:32], exp[i]); end
      tick();
      bif.data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_lw_late();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus = mk_bus(32'h200, 32'h3000, 5'd4, 4'hF, 6'd0, 8'd0, 3'd5, 1'b1);
    tick();
    bif.es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bif.ms_to_ws_valid !== 1'b0 || bif.ms_allowin !== 1'b0) begin
        fails++; $display("FAIL late_wait_%0d got valid=%b allowin=%b want 0 0", i,
                          bif.ms_to_ws_valid, bif.ms_allowin); end
      tick();
    end
    bif.data_sram_data_ok = 1'b1;
    bif.data_sram_rdata = 32'hCAFEF00D;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b1 || bif.ms_to_ws_bus[63:32] !== 32'hCAFEF00D) begin
      fails++; $display("FAIL late_done got valid=%b data=%h want 1 cafef00d",
                        bif.ms_to_ws_valid, bif.ms_to_ws_bus[63:32]); end
    tick();
    bif.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_ws_stall();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus = mk_bus(32'h300, 32'h4000, 5'd6, 4'hF, 6'd0, 8'd0, 3'd5, 1'b1);
    tick();
    bif.es_to_ms_valid = 1'b0;
    bif.ws_allowin = 1'b0;
    bif.data_sram_data_ok = 1'b1;
    bif.data_sram_rdata = 32'hDEADBEEF;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b1 || bif.ms_allowin !== 1'b0) begin
      fails++; $display("FAIL stall_arrive got valid=%b allowin=%b want 1 0",
                        bif.ms_to_ws_valid, bif.ms_allowin); end
    tick();
    bif.data_sram_data_ok = 1'b0;
    bif.data_sram_rdata = 32'h0;
    #1;
    tests++; if (bif.ms_to_ws_bus[63:32] !== 32'hDEADBEEF || bif.ms_allowin !== 1'b0) begin
      fails++; $display("FAIL stall_hold got data=%h allowin=%b want deadbeef 0",
                        bif.ms_to_ws_bus[63:32], bif.ms_allowin); end
    tick();
    bif.ws_allowin = 1'b1;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b1 || bif.ms_to_ws_bus[63:32] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL stall_release got valid=%b data=%h want 1 deadbeef",
                        bif.ms_to_ws_valid, bif.ms_to_ws_bus[63:32]); end
    tick();
    bif.data_sram_data_ok = 1'b1;
    bif.data_sram_rdata = 32'h55555555;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b0 || bif.ms_allowin !== 1'b1) begin
      fails++; $display("FAIL stray_resp got valid=%b allowin=%b want 0 1",
                        bif.ms_to_ws_valid, bif.ms_allowin); end
    tick();
    bif.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_cancel();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus = mk_bus(32'h400, 32'h5000, 5'd7, 4'hF, 6'd0, 8'd0, 3'd5, 1'b1);
    tick();
    bif.es_to_ms_valid = 1'b0;
    bif.flush = 1'b1;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b0) begin
      fails++; $display("FAIL flush_valid got %b want 0", bif.ms_to_ws_valid); end
    tick();
    bif.flush = 1'b0;
    #1;
    tests++; if (bif.ms_rf_dest !== 5'd0 || bif.ms_allowin !== 1'b1 ||
                 dut.cancel_cnt_q !== 2'd1) begin
      fails++; $display("FAIL flush_after got dest=%0d allowin=%b cnt=%0d want 0 1 1",
                        bif.ms_rf_dest, bif.ms_allowin, dut.cancel_cnt_q); end
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus = mk_bus(32'h404, 32'h5004, 5'd8, 4'hF, 6'd0, 8'd0, 3'd5, 1'b1);
    tick();
    bif.es_to_ms_valid = 1'b0;
    bif.data_sram_data_ok = 1'b1;
    bif.data_sram_rdata = 32'h11111111;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b0 || bif.ms_allowin !== 1'b0) begin
      fails++; $display("FAIL stale_drop got valid=%b allowin=%b want 0 0",
                        bif.ms_to_ws_valid, bif.ms_allowin); end
    tick();
    bif.data_sram_rdata = 32'h22222222;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b1 || bif.ms_to_ws_bus[63:32] !== 32'h22222222) begin
      fails++; $display("FAIL own_data got valid=%b data=%h want 1 22222222",
                        bif.ms_to_ws_valid, bif.ms_to_ws_bus[63:32]); end
    tick();
    bif.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus = mk_bus(32'h500, 32'h6000, 5'd9, 4'hF, 6'd0, 8'd0, 3'd5, 1'b1);
    tick();
    bif.es_to_ms_valid = 1'b0;
    bif.flush = 1'b1;
    tick();
    bif.flush = 1'b0;
    bif.es_to_ms_valid = 1'b1;
    tick();
    bif.es_to_ms_valid = 1'b0;
    #1;
    tests++; if (dut.cancel_cnt_q !== 2'd1 || bif.ms_rf_dest !== 5'd9) begin
      fails++; $display("FAIL pre_reset got cnt=%0d dest=%0d want 1 9",
                        dut.cancel_cnt_q, bif.ms_rf_dest); end
    resetn = 1'b0;
    #1;
    tests++; if (bif.ms_allowin !== 1'b1 || bif.ms_to_ws_valid !== 1'b0 ||
                 bif.ms_rf_dest !== 5'd0 || dut.cancel_cnt_q !== 2'd0 ||
                 bif.ms_to_ws_bus !== 87'd0) begin
      fails++; $display("FAIL mid_reset got allowin=%b valid=%b dest=%0d cnt=%0d want 1 0 0 0",
                        bif.ms_allowin, bif.ms_to_ws_valid, bif.ms_rf_dest, dut.cancel_cnt_q);
    end
    #2;
    resetn = 1'b1;
    tick();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus = mk_bus(32'h600, 32'h7000, 5'd10, 4'hF, 6'd0, 8'd0, 3'd5, 1'b1);
    tick();
    bif.es_to_ms_valid = 1'b0;
    bif.data_sram_data_ok = 1'b1;
    bif.data_sram_rdata = 32'h33333333;
    #1;
    tests++; if (bif.ms_to_ws_valid !== 1'b1 || bif.ms_to_ws_bus[63:32] !== 32'h33333333) begin
      fails++; $display("FAIL post_reset_lw got valid=%b data=%h want 1 33333333",
                        bif.ms_to_ws_valid, bif.ms_to_ws_bus[63:32]); end
    tick();
    bif.data_sram_data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_align();
    test_lw_late();
    test_ws_stall();
    test_flush_cancel();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
